// File: rtl/y86_pkg.sv
// Shared Y86 encodings and field types used by every pipeline register.
package y86_pkg;

    typedef logic [2:0] stat_t;
    typedef logic [3:0] icode_t;
    typedef logic [3:0] reg_id_t;

    localparam stat_t   SAOK  = 3'd1;
    localparam stat_t   SHLT  = 3'd2;
    localparam stat_t   SADR  = 3'd3;
    localparam stat_t   SINS  = 3'd4;
    localparam icode_t  INOP  = 4'h1;
    localparam reg_id_t RNONE = 4'hF;

endpackage

// File: rtl/y86_pipe_reg_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones, cleared by rst.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/y86_pipe_reg.sv
// Generic Y86 pipeline register (F/D, D/E, E/M, M/W) with stall and bubble control.
// Optional stall/bubble counters are enabled by defining PIPE_REG_STATS_EN.
module y86_pipe_reg
    import y86_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic [2:0]        in_stat,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [WORD_W-1:0] in_valC,
    input  logic [WORD_W-1:0] in_valP,
    input  logic [WORD_W-1:0] in_valA,
    input  logic [WORD_W-1:0] in_valB,
    input  logic [WORD_W-1:0] in_valE,
    input  logic              in_cnd,
    output logic [2:0]        out_stat,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_rA,
    output logic [3:0]        out_rB,
    output logic [WORD_W-1:0] out_valC,
    output logic [WORD_W-1:0] out_valP,
    output logic [WORD_W-1:0] out_valA,
    output logic [WORD_W-1:0] out_valB,
    output logic              out_cnd,
    output logic [WORD_W-1:0] out_valE,
    output logic              out_is_bubble
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    stat_t             stat_q,  stat_d;
    icode_t            icode_q, icode_d;
    reg_id_t           ra_q,    ra_d;
    reg_id_t           rb_q,    rb_d;
    logic [WORD_W-1:0] valc_q,  valc_d;
    logic [WORD_W-1:0] valp_q,  valp_d;
    logic [WORD_W-1:0] vala_q,  vala_d;
    logic [WORD_W-1:0] valb_q,  valb_d;
    logic [WORD_W-1:0] vale_q,  vale_d;
    logic              cnd_q,   cnd_d;
    logic              bub_q,   bub_d;

    // Bubble outranks stall; reset is applied in the register process itself.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        vala_d  = vala_q;
        valb_d  = valb_q;
        vale_d  = vale_q;
        cnd_d   = cnd_q;
        bub_d   = bub_q;
        if (bubble) begin
            stat_d  = SAOK;
            icode_d = INOP;
            ra_d    = RNONE;
            rb_d    = RNONE;
            valc_d  = '0;
            valp_d  = '0;
            vala_d  = '0;
            valb_d  = '0;
            vale_d  = '0;
            cnd_d   = 1'b0;
            bub_d   = 1'b1;
        end else if (!stall) begin
            stat_d  = in_stat;
            icode_d = in_icode;
            ra_d    = in_rA;
            rb_d    = in_rB;
            valc_d  = in_valC;
            valp_d  = in_valP;
            vala_d  = in_valA;
            valb_d  = in_valB;
            vale_d  = in_valE;
            cnd_d   = in_cnd;
            bub_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q  <= SAOK;
            icode_q <= INOP;
            ra_q    <= RNONE;
            rb_q    <= RNONE;
            valc_q  <= '0;
            valp_q  <= '0;
            vala_q  <= '0;
            valb_q  <= '0;
            vale_q  <= '0;
            cnd_q   <= 1'b0;
            bub_q   <= 1'b1;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
            vale_q  <= vale_d;
            cnd_q   <= cnd_d;
            bub_q   <= bub_d;
        end
    end

    assign out_stat      = stat_q;
    assign out_icode     = icode_q;
    assign out_rA        = ra_q;
    assign out_rB        = rb_q;
    assign out_valC      = valc_q;
    assign out_valP      = valp_q;
    assign out_valA      = vala_q;
    assign out_valB      = valb_q;
    assign out_valE      = vale_q;
    assign out_cnd       = cnd_q;
    assign out_is_bubble = bub_q;

`ifdef PIPE_REG_STATS_EN
    // A stall masked by a simultaneous bubble is not counted.
    logic stall_inc;
    assign stall_inc = stall & ~bubble;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble),
        .count (bubble_cnt)
    );
`else
    // Statistics disabled: no counter state or ports.
`endif

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Directed self-checking bench for y86_pipe_reg; counter checks need PIPE_REG_STATS_EN.
module tb_y86_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, bubble;
    logic [2:0]  in_stat;
    logic [3:0]  in_icode, in_rA, in_rB;
    logic [63:0] in_valC, in_valP, in_valA, in_valB, in_valE;
    logic        in_cnd;

    logic [2:0]  out_stat;
    logic [3:0]  out_icode, out_rA, out_rB;
    logic [63:0] out_valC, out_valP, out_valA, out_valB, out_valE;
    logic        out_cnd, out_is_bubble;

    logic [2:0]  s_stat;
    logic [3:0]  s_icode, s_rA, s_rB;
    logic [63:0] s_valC, s_valP, s_valA, s_valB, s_valE;
    logic        s_cnd, s_is_bubble;

`ifdef PIPE_REG_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [1:0]  s_stall_cnt, s_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    y86_pipe_reg #(.WORD_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_valP(in_valP), .in_valA(in_valA),
        .in_valB(in_valB), .in_valE(in_valE), .in_cnd(in_cnd),
        .out_stat(out_stat), .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB),
        .out_valC(out_valC), .out_valP(out_valP), .out_valA(out_valA),
        .out_valB(out_valB), .out_cnd(out_cnd), .out_valE(out_valE),
        .out_is_bubble(out_is_bubble)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    y86_pipe_reg #(.WORD_W(64), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_valP(in_valP), .in_valA(in_valA),
        .in_valB(in_valB), .in_valE(in_valE), .in_cnd(in_cnd),
        .out_stat(s_stat), .out_icode(s_icode), .out_rA(s_rA), .out_rB(s_rB),
        .out_valC(s_valC), .out_valP(s_valP), .out_valA(s_valA),
        .out_valB(s_valB), .out_cnd(s_cnd), .out_valE(s_valE),
        .out_is_bubble(s_is_bubble)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; bubble = 1'b0;
        in_stat = 3'd3; in_icode = 4'h7; in_rA = 4'h2; in_rB = 4'h3;
        in_valC = 64'h11; in_valP = 64'h22; in_valA = 64'h33; in_valB = 64'h44;
        in_valE = 64'h55; in_cnd = 1'b1;
        step();
        total++; if (out_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%0h exp=1", out_icode); end
        total++; if (out_stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d exp=1", out_stat); end
        total++; if (out_rA !== 4'hF || out_rB !== 4'hF) begin bad++; $display("FAIL reset_regs got=%0h/%0h exp=f/f", out_rA, out_rB); end
        total++; if ({out_valC, out_valP, out_valA, out_valB, out_valE} !== '0) begin bad++; $display("FAIL reset_vals got=%0h/%0h/%0h/%0h/%0h exp=0", out_valC, out_valP, out_valA, out_valB, out_valE); end
        total++; if (out_cnd !== 1'b0) begin bad++; $display("FAIL reset_cnd got=%0b exp=0", out_cnd); end
        total++; if (out_is_bubble !== 1'b1) begin bad++; $display("FAIL reset_is_bubble got=%0b exp=1", out_is_bubble); end
`ifdef PIPE_REG_STATS_EN
        total++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
`endif
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_load();
        in_stat = 3'd1; in_icode = 4'h6; in_rA = 4'h2; in_rB = 4'h5;
        in_valC = 64'h11; in_valP = 64'h22; in_valA = 64'h33; in_valB = 64'h44;
        in_valE = 64'h1234; in_cnd = 1'b1;
        #1;
        total++; if (out_icode !== 4'h1) begin bad++; $display("FAIL load_no_comb got=%0h exp=1", out_icode); end
        step();
        total++; if (out_icode !== 4'h6) begin bad++; $display("FAIL load_icode got=%0h exp=6", out_icode); end
        total++; if (out_valE !== 64'h1234) begin bad++; $display("FAIL load_valE got=%0h exp=1234", out_valE); end
        total++; if (out_cnd !== 1'b1) begin bad++; $display("FAIL load_cnd got=%0b exp=1", out_cnd); end
        total++; if (out_is_bubble !== 1'b0) begin bad++; $display("FAIL load_is_bubble got=%0b exp=0", out_is_bubble); end
        total++; if (out_rA !== 4'h2 || out_rB !== 4'h5 || out_valC !== 64'h11 || out_valB !== 64'h44) begin bad++; $display("FAIL load_fields got=%0h/%0h/%0h/%0h exp=2/5/11/44", out_rA, out_rB, out_valC, out_valB); end
    endtask

    task automatic test_stall();
        in_valE = 64'hAA;
        step();
        total++; if (out_valE !== 64'hAA) begin bad++; $display("FAIL stall_preload got=%0h exp=aa", out_valE); end
        stall = 1'b1; in_valE = 64'hBB; in_icode = 4'h2;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valE !== 64'hAA || out_icode !== 4'h6 || out_is_bubble !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got=%0h/%0h/%0b exp=aa/6/0", i, out_valE, out_icode, out_is_bubble); end
        end
`ifdef PIPE_REG_STATS_EN
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        total++; if (s_stall_cnt !== 2'd3) begin bad++; $display("FAIL stall_cnt_w2 got=%0d exp=3", s_stall_cnt); end
`endif
        stall = 1'b0;
        step();
        total++; if (out_valE !== 64'hBB || out_icode !== 4'h2) begin bad++; $display("FAIL stall_release got=%0h/%0h exp=bb/2", out_valE, out_icode); end
    endtask

    task automatic test_bubble_stall();
        bubble = 1'b1; stall = 1'b1;
        step();
        total++; if (out_icode !== 4'h1 || out_stat !== 3'd1) begin bad++; $display("FAIL bub_codes got=%0h/%0d exp=1/1", out_icode, out_stat); end
        total++; if (out_rA !== 4'hF || out_rB !== 4'hF || out_cnd !== 1'b0) begin bad++; $display("FAIL bub_regs got=%0h/%0h/%0b exp=f/f/0", out_rA, out_rB, out_cnd); end
        total++; if ({out_valC, out_valP, out_valA, out_valB, out_valE} !== '0) begin bad++; $display("FAIL bub_vals got=%0h/%0h/%0h/%0h/%0h exp=0", out_valC, out_valP, out_valA, out_valB, out_valE); end
        total++; if (out_is_bubble !== 1'b1) begin bad++; $display("FAIL bub_is_bubble got=%0b exp=1", out_is_bubble); end
`ifdef PIPE_REG_STATS_EN
        total++; if (bubble_cnt !== 32'd1) begin bad++; $display("FAIL bub_cnt got=%0d exp=1", bubble_cnt); end
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL bub_stall_cnt got=%0d exp=3", stall_cnt); end
`endif
        bubble = 1'b0; stall = 1'b0;
    endtask

    task automatic test_saturation();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++; if (out_is_bubble !== 1'b1 || out_valE !== 64'h0) begin bad++; $display("FAIL sat_hold got=%0b/%0h exp=1/0", out_is_bubble, out_valE); end
`ifdef PIPE_REG_STATS_EN
        total++; if (s_stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt_w2 got=%0d exp=3", s_stall_cnt); end
        total++; if (stall_cnt !== 32'd8) begin bad++; $display("FAIL sat_cnt_w32 got=%0d exp=8", stall_cnt); end
`endif
        stall = 1'b0;
    endtask

    task automatic test_passthrough();
        in_stat = 3'd4; in_icode = 4'hD;
        step();
        total++; if (out_stat !== 3'd4 || out_icode !== 4'hD) begin bad++; $display("FAIL pass_codes got=%0d/%0h exp=4/d", out_stat, out_icode); end
        total++; if (out_is_bubble !== 1'b0) begin bad++; $display("FAIL pass_is_bubble got=%0b exp=0", out_is_bubble); end
    endtask

    task automatic test_reset_drops_stall();
        rst = 1'b1; stall = 1'b1; bubble = 1'b1;
        step();
        total++; if (out_icode !== 4'h1 || out_is_bubble !== 1'b1) begin bad++; $display("FAIL rst_over got=%0h/%0b exp=1/1", out_icode, out_is_bubble); end
`ifdef PIPE_REG_STATS_EN
        total++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || s_stall_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, bubble_cnt, s_stall_cnt); end
`endif
        rst = 1'b0; stall = 1'b0; bubble = 1'b0; in_valE = 64'h55;
        step();
        total++; if (out_valE !== 64'h55 || out_is_bubble !== 1'b0) begin bad++; $display("FAIL rst_after got=%0h/%0b exp=55/0", out_valE, out_is_bubble); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        in_stat = '0; in_icode = '0; in_rA = '0; in_rB = '0;
        in_valC = '0; in_valP = '0; in_valA = '0; in_valB = '0; in_valE = '0;
        in_cnd = 1'b0;
        test_reset();
        test_load();
        test_stall();
        test_bubble_stall();
        test_saturation();
        test_passthrough();
        test_reset_drops_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
